// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
package sync_fifo_param_pkg;

  localparam int unsigned DEFAULT_DATA_W = 4;
  localparam int unsigned DEFAULT_DEPTH  = 4;

  // Accepted-operation encoding {push_ok, pop_ok} used by the occupancy update.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param.
interface sync_fifo_param_if
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_in;
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              fifo_empty;
  logic              fifo_full;
  logic              almost_empty;
  logic              almost_full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  // Client side: drives requests, observes status.
  modport master (
    output data_in, push, pop, clr_err,
    input  data_out, fifo_empty, fifo_full, almost_empty, almost_full,
           count, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  data_in, push, pop, clr_err,
    output data_out, fifo_empty, fifo_full, almost_empty, almost_full,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_wrap_ptr.sv
// DEPTH-modulo pointer: counts 0..DEPTH-1 and wraps by explicit compare.
module sync_fifo_param_wrap_ptr
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next pointer: hold, or advance with wrap at DEPTH-1.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) ptr_d = '0;
      else                            ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock circular FIFO with show-ahead read, occupancy count,
// almost-full/empty thresholds and sticky overflow/underflow flags.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              reset,
  sync_fifo_param_if.slave  bus
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);
  localparam int unsigned PTR_W = clog2(DEPTH);

  // Elaboration-time parameter sanity.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("sync_fifo_param: DATA_W must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be >= 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             empty_q,     empty_d;
  logic             full_q,      full_d;
  logic             aempty_q,    aempty_d;
  logic             afull_q,     afull_d;
  logic             overflow_q,  overflow_d;
  logic             underflow_q, underflow_d;

  logic     push_ok;
  logic     pop_ok;
  fifo_op_e op;

  // Accept decisions, next occupancy and next-state status flags.
  always_comb begin
    push_ok     = bus.push & (~full_q | bus.pop);
    pop_ok      = bus.pop & ~empty_q;
    op          = fifo_op_e'({push_ok, pop_ok});
    count_d     = count_q;
    case (op)
      OP_PUSH: count_d = count_q + CNT_W'(1);
      OP_POP:  count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    empty_d     = (count_d == '0);
    full_d      = (count_d == CNT_W'(DEPTH));
    aempty_d    = (count_d <= CNT_W'(AE_LEVEL));
    afull_d     = (count_d >= CNT_W'(AF_LEVEL));
    // A new error event in the clearing cycle keeps the flag set.
    overflow_d  = (overflow_q & ~bus.clr_err) | (bus.push & full_q & ~bus.pop);
    underflow_d = (underflow_q & ~bus.clr_err) | (bus.pop & empty_q);
  end

  // Write and read pointers.
  sync_fifo_param_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (push_ok),
    .ptr_o (wr_ptr)
  );

  sync_fifo_param_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (pop_ok),
    .ptr_o (rd_ptr)
  );

  // Storage write; contents survive reset, but reset blocks a same-cycle push.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr] <= bus.data_in;
  end

  // Occupancy and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      aempty_q    <= 1'b1;
      afull_q     <= (AF_LEVEL == 0);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      aempty_q    <= aempty_d;
      afull_q     <= afull_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Show-ahead head word straight from storage; status from registers.
  assign bus.data_out     = mem_q[rd_ptr];
  assign bus.count        = count_q;
  assign bus.fifo_empty   = empty_q;
  assign bus.fifo_full    = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
